// File: rtl/rv32i_ex_seq_pkg.sv
// Shared types, opcode constants and instruction encoders for the EX-stage
// test-vector sequencer and its vector ROM.
package rv32i_ex_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        PAUSE,
        NEXT,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] expected;
        logic        check_en;
    } ex_vector_t;

    localparam int EX_VECTOR_W = $bits(ex_vector_t);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Encoders use fixed registers (rd=x3, rs1=x1, rs2=x2); EX only sees operand values.
    function automatic logic [31:0] enc_r(input logic [6:0] funct7, input logic [2:0] funct3);
        return {funct7, 5'd2, 5'd1, funct3, 5'd3, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] funct3,
                                          input logic [6:0] opcode);
        return {imm, 5'd1, funct3, 5'd3, opcode};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] funct3);
        return {imm[11:5], 5'd2, 5'd1, funct3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] opcode);
        return {imm, 5'd3, opcode};
    endfunction

    function automatic ex_vector_t mk_vec(input logic [31:0] pc, input logic [31:0] iw,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] expected);
        ex_vector_t v;
        v.pc       = pc;
        v.iw       = iw;
        v.rs1      = rs1;
        v.rs2      = rs2;
        v.expected = expected;
        v.check_en = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rv32i_ex_vector_rom.sv
// Combinational vector ROM: hand-written R/I/S/U/J vectors followed by
// generated ADD vectors. Indices at or beyond NUM_VECTORS read as all-zero.
module rv32i_ex_vector_rom
    import rv32i_ex_seq_pkg::*;
#(
    parameter int NUM_VECTORS = 32,
    parameter int IDX_W       = 5
) (
    input  logic [IDX_W-1:0]       index,
    output logic [EX_VECTOR_W-1:0] vector
);

    logic [31:0] idx32;
    ex_vector_t  v;

    assign idx32 = 32'(index);

    always_comb begin
        v = '0;
        if (idx32 < 32'(NUM_VECTORS)) begin
            case (idx32)
                32'd0:  v = mk_vec(32'h0000_0000, 32'h0000_0033, 32'h0200_0000, 32'h3000_0000, 32'h3200_0000);
                32'd1:  v = mk_vec(32'h0000_0004, enc_r(7'h20, 3'b000), 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
                32'd2:  v = mk_vec(32'h0000_0008, enc_i(12'hFFF, 3'b000, OP_I), 32'h0000_0010, 32'h0, 32'h0000_000F);
                32'd3:  v = mk_vec(32'h0000_000C, enc_u(20'h12345, OP_LUI), 32'h0, 32'h0, 32'h1234_5000);
                32'd4:  v = mk_vec(32'h0000_0100, enc_u(20'h00001, OP_AUIPC), 32'h0, 32'h0, 32'h0000_1100);
                32'd5:  v = mk_vec(32'h0000_0200, {20'h00000, 5'd1, OP_JAL}, 32'h0, 32'h0, 32'h0000_0204);
                32'd6:  v = mk_vec(32'h0000_0018, enc_s(12'h008, 3'b010), 32'h0000_1000, 32'h1234_5678, 32'h0000_1008);
                32'd7:  v = mk_vec(32'h0000_001C, enc_r(7'h00, 3'b111), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
                32'd8:  v = mk_vec(32'h0000_0020, enc_r(7'h00, 3'b100), 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
                32'd9:  v = mk_vec(32'h0000_0024, enc_r(7'h20, 3'b101), 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
                32'd10: v = mk_vec(32'h0000_0028, enc_r(7'h00, 3'b011), 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
                32'd11: v = mk_vec(32'h0000_002C, enc_i(12'hFFC, 3'b010, OP_LOAD), 32'h0000_2000, 32'h0, 32'h0000_1FFC);
                32'd12: v = mk_vec(32'h0000_0300, enc_i(12'h000, 3'b000, OP_JALR), 32'h0000_4000, 32'h0, 32'h0000_0304);
                32'd13: v = mk_vec(32'h0000_0034, enc_i(12'h0F0, 3'b110, OP_I), 32'h0000_0F00, 32'h0, 32'h0000_0FF0);
                32'd14: v = mk_vec(32'h0000_0038, enc_r(7'h00, 3'b010), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
                32'd15: v = mk_vec(32'h0000_003C, enc_r(7'h00, 3'b001), 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
                default: v = mk_vec(idx32 << 2, enc_r(7'h00, 3'b000), idx32 << 8, idx32, (idx32 << 8) + idx32);
            endcase
            // Observation-only slot: the bogus expected value must never be scored.
            if (idx32 == 32'd20) begin
                v.expected = 32'hDEAD_BEEF;
                v.check_en = 1'b0;
            end
        end
    end

    assign vector = v;

endmodule

// File: rtl/rv32i_ex_sequencer.sv
// Steps through the vector ROM, drives each vector into the EX stage, scores
// ex_result EX_LATENCY cycles later and keeps pass/fail status for the board.
module rv32i_ex_sequencer
    import rv32i_ex_seq_pkg::*;
#(
    parameter int NUM_VECTORS = 32,
    parameter int EX_LATENCY  = 2,
    parameter int IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    parameter int CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [31:0]      ex_result,
    output logic [31:0]      pc_out,
    output logic [31:0]      iw_out,
    output logic [31:0]      rs1_data_out,
    output logic [31:0]      rs2_data_out,
    output logic             valid_out,
    output logic [IDX_W-1:0] vec_index,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             fail_flag,
    output logic             busy,
    output logic             done
);

    localparam int              WAIT_W   = $clog2(EX_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    seq_state_t             state;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [IDX_W-1:0]       rom_index;
    logic [EX_VECTOR_W-1:0] rom_bits;
    ex_vector_t             rom_vec;
    logic [31:0]            exp_value;
    logic                   exp_check_en;
    logic                   start_run;
    logic                   advance;

    assign start_run = start && ((state == IDLE) || (state == DONE));
    assign advance   = (state == NEXT) && (vec_index != LAST_IDX);
    // The ROM is addressed with the index of the vector about to be issued.
    assign rom_index = advance ? vec_index + 1'b1 : '0;

    rv32i_ex_vector_rom #(
        .NUM_VECTORS(NUM_VECTORS),
        .IDX_W      (IDX_W)
    ) u_rom (
        .index (rom_index),
        .vector(rom_bits)
    );

    assign rom_vec = rom_bits;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_out       <= '0;
            iw_out       <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            exp_value    <= '0;
            exp_check_en <= 1'b0;
        end else if (start_run || advance) begin
            pc_out       <= rom_vec.pc;
            iw_out       <= rom_vec.iw;
            rs1_data_out <= rom_vec.rs1;
            rs2_data_out <= rom_vec.rs2;
            exp_value    <= rom_vec.expected;
            exp_check_en <= rom_vec.check_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            valid_out      <= 1'b0;
            vec_index      <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            fail_flag      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= ISSUE;
                        valid_out      <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        vec_index      <= '0;
                        pass_count     <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        fail_flag      <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (EX_LATENCY > 1) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        state <= CHECK;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_W'(EX_LATENCY - 1)) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (exp_check_en) begin
                        if (ex_result == exp_value) begin
                            pass_count <= pass_count + 1'b1;
                        end else begin
                            fail_count <= fail_count + 1'b1;
                            if (!fail_flag) begin
                                fail_flag      <= 1'b1;
                                first_fail_idx <= vec_index;
                            end
                        end
                    end
                    state <= step_mode ? PAUSE : NEXT;
                end
                PAUSE: begin
                    if (step) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (vec_index == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= ISSUE;
                        valid_out <= 1'b1;
                        vec_index <= vec_index + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_ex_sequencer.sv
// Self-checking bench: three sequencer instances (4x lat2, 32x lat1, 1x lat3)
// fed by an independent RV32I ALU model of the EX stage.
module tb_rv32i_ex_sequencer;

    logic        clk;
    logic        rst_a, start_a, step_mode_a, step_a;
    logic [31:0] ex_a, pc_a, iw_a, rs1_a, rs2_a;
    logic        valid_a, flag_a, busy_a, done_a;
    logic [1:0]  idx_a, ffi_a;
    logic [2:0]  pass_a, fail_a;
    logic [3:0]  corrupt_a;

    logic        rst_bc, start_b, start_c, zero_in;
    logic [31:0] ex_b, pc_b, iw_b, rs1_b, rs2_b;
    logic        valid_b, flag_b, busy_b, done_b;
    logic [4:0]  idx_b, ffi_b;
    logic [5:0]  pass_b, fail_b;
    logic [31:0] ex_c, pc_c, iw_c, rs1_c, rs2_c;
    logic        valid_c, flag_c, busy_c, done_c;
    logic [0:0]  idx_c, ffi_c;
    logic [0:0]  pass_c, fail_c;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [1:0]  idx;
        logic        busy;
        logic        done;
        logic [2:0]  pass_c;
        logic [2:0]  fail_c;
        logic [31:0] iw;
    } t1_vec_t;

    t1_vec_t tbl [11];

    function automatic logic [31:0] exModel(input logic [31:0] pc, input logic [31:0] iw,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] imm_i, imm_s, imm_u, opb, r;
        logic [4:0]  sh;
        imm_i = {{20{iw[31]}}, iw[31:20]};
        imm_s = {{20{iw[31]}}, iw[31:25], iw[11:7]};
        imm_u = {iw[31:12], 12'b0};
        opb   = (iw[6:0] == 7'b0110011) ? b : imm_i;
        sh    = opb[4:0];
        r     = 32'h0;
        case (iw[6:0])
            7'b0110011, 7'b0010011: begin
                case (iw[14:12])
                    3'd0: r = (iw[6:0] == 7'b0110011 && iw[30]) ? a - opb : a + opb;
                    3'd1: r = a << sh;
                    3'd2: r = {31'b0, $signed(a) < $signed(opb)};
                    3'd3: r = {31'b0, a < opb};
                    3'd4: r = a ^ opb;
                    3'd5: r = iw[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: r = a | opb;
                    default: r = a & opb;
                endcase
            end
            7'b0000011: r = a + imm_i;
            7'b0100011: r = a + imm_s;
            7'b0110111: r = imm_u;
            7'b0010111: r = pc + imm_u;
            7'b1101111, 7'b1100111: r = pc + 32'd4;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign ex_a = exModel(pc_a, iw_a, rs1_a, rs2_a) ^ {31'b0, corrupt_a[idx_a]};
    assign ex_b = exModel(pc_b, iw_b, rs1_b, rs2_b);
    assign ex_c = exModel(pc_c, iw_c, rs1_c, rs2_c);

    rv32i_ex_sequencer #(.NUM_VECTORS(4), .EX_LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .step_mode(step_mode_a), .step(step_a),
        .ex_result(ex_a), .pc_out(pc_a), .iw_out(iw_a), .rs1_data_out(rs1_a),
        .rs2_data_out(rs2_a), .valid_out(valid_a), .vec_index(idx_a), .pass_count(pass_a),
        .fail_count(fail_a), .first_fail_idx(ffi_a), .fail_flag(flag_a), .busy(busy_a),
        .done(done_a)
    );

    rv32i_ex_sequencer #(.NUM_VECTORS(32), .EX_LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_bc), .start(start_b), .step_mode(zero_in), .step(zero_in),
        .ex_result(ex_b), .pc_out(pc_b), .iw_out(iw_b), .rs1_data_out(rs1_b),
        .rs2_data_out(rs2_b), .valid_out(valid_b), .vec_index(idx_b), .pass_count(pass_b),
        .fail_count(fail_b), .first_fail_idx(ffi_b), .fail_flag(flag_b), .busy(busy_b),
        .done(done_b)
    );

    rv32i_ex_sequencer #(.NUM_VECTORS(1), .EX_LATENCY(3)) dut_c (
        .clk(clk), .reset(rst_bc), .start(start_c), .step_mode(zero_in), .step(zero_in),
        .ex_result(ex_c), .pc_out(pc_c), .iw_out(iw_c), .rs1_data_out(rs1_c),
        .rs2_data_out(rs2_c), .valid_out(valid_c), .vec_index(idx_c), .pass_count(pass_c),
        .fail_count(fail_c), .first_fail_idx(ffi_c), .fail_flag(flag_c), .busy(busy_c),
        .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_step, input logic s_mode);
        start_a     = s_start;
        step_a      = s_step;
        step_mode_a = s_mode;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkIdleA(input string p);
        checkOutput({p, "_pc"}, pc_a, 32'h0);
        checkOutput({p, "_iw"}, iw_a, 32'h0);
        checkOutput({p, "_rs1"}, rs1_a, 32'h0);
        checkOutput({p, "_rs2"}, rs2_a, 32'h0);
        checkOutput({p, "_valid"}, valid_a, 32'h0);
        checkOutput({p, "_idx"}, idx_a, 32'h0);
        checkOutput({p, "_pass"}, pass_a, 32'h0);
        checkOutput({p, "_fail"}, fail_a, 32'h0);
        checkOutput({p, "_ffi"}, ffi_a, 32'h0);
        checkOutput({p, "_flag"}, flag_a, 32'h0);
        checkOutput({p, "_busy"}, busy_a, 32'h0);
        checkOutput({p, "_done"}, done_a, 32'h0);
    endtask

    task automatic waitDoneA(input string p, input int max_cycles);
        for (int i = 0; i < max_cycles && !done_a; i++) tick();
        checkOutput({p, "_done_reached"}, done_a, 32'h1);
    endtask

    task automatic startA();
        applyStimulus(1'b1, 1'b0, step_mode_a);
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int bad_v, bad_d, bad_hold;
        logic exp_v;

        tbl[0]  = '{1,  1'b1, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0033};
        tbl[1]  = '{2,  1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0033};
        tbl[2]  = '{3,  1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0033};
        tbl[3]  = '{4,  1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 3'd0, 32'h0000_0033};
        tbl[4]  = '{5,  1'b1, 2'd1, 1'b1, 1'b0, 3'd1, 3'd0, 32'h4020_81B3};
        tbl[5]  = '{8,  1'b0, 2'd1, 1'b1, 1'b0, 3'd2, 3'd0, 32'h4020_81B3};
        tbl[6]  = '{9,  1'b1, 2'd2, 1'b1, 1'b0, 3'd2, 3'd0, 32'hFFF0_8193};
        tbl[7]  = '{12, 1'b0, 2'd2, 1'b1, 1'b0, 3'd3, 3'd0, 32'hFFF0_8193};
        tbl[8]  = '{13, 1'b1, 2'd3, 1'b1, 1'b0, 3'd3, 3'd0, 32'h1234_51B7};
        tbl[9]  = '{16, 1'b0, 2'd3, 1'b1, 1'b0, 3'd4, 3'd0, 32'h1234_51B7};
        tbl[10] = '{17, 1'b0, 2'd3, 1'b0, 1'b1, 3'd4, 3'd0, 32'h1234_51B7};

        rst_a = 1'b0; rst_bc = 1'b0; zero_in = 1'b0;
        start_b = 1'b0; start_c = 1'b0; corrupt_a = 4'b0000;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checkIdleA("reset");
        checkOutput("reset_b_busy", busy_b, 32'h0);
        rst_a = 1'b1;

        $display("[TB] throughput and operand sequencing, 4 vectors, latency 2");
        startA();
        for (int c = 1; c <= 17; c++) begin
            checkOutput($sformatf("t1_valid_c%0d", c), valid_a, (c == 1 || c == 5 || c == 9 || c == 13));
            for (int t = 0; t < 11; t++) begin
                if (tbl[t].cyc == c) begin
                    checkOutput($sformatf("t1_idx_c%0d", c), idx_a, tbl[t].idx);
                    checkOutput($sformatf("t1_busy_c%0d", c), busy_a, tbl[t].busy);
                    checkOutput($sformatf("t1_done_c%0d", c), done_a, tbl[t].done);
                    checkOutput($sformatf("t1_pass_c%0d", c), pass_a, tbl[t].pass_c);
                    checkOutput($sformatf("t1_fail_c%0d", c), fail_a, tbl[t].fail_c);
                    checkOutput($sformatf("t1_iw_c%0d", c), iw_a, tbl[t].iw);
                end
            end
            if (c == 1) begin
                checkOutput("t1_pc0", pc_a, 32'h0);
                checkOutput("t1_rs1_0", rs1_a, 32'h0200_0000);
                checkOutput("t1_rs2_0", rs2_a, 32'h3000_0000);
            end
            if (c == 7) checkOutput("t1_rs1_hold", rs1_a, 32'h0000_0005);
            tick();
        end
        checkOutput("t1_final_flag", flag_a, 32'h0);
        checkOutput("t1_final_done", done_a, 32'h1);

        $display("[TB] mismatch on vector 0, start while busy ignored");
        corrupt_a = 4'b0001;
        startA();
        checkOutput("t2_valid", valid_a, 32'h1);
        checkOutput("t2_pass_cleared", pass_a, 32'h0);
        repeat (3) tick();
        checkOutput("t2_fail_early", fail_a, 32'h1);
        checkOutput("t2_flag_early", flag_a, 32'h1);
        repeat (2) tick();
        startA();
        checkOutput("t2_busy_start_idx", idx_a, 32'h1);
        checkOutput("t2_busy_start_valid", valid_a, 32'h0);
        checkOutput("t2_busy_start_fail", fail_a, 32'h1);
        waitDoneA("t2", 40);
        checkOutput("t2_pass", pass_a, 32'h3);
        checkOutput("t2_fail", fail_a, 32'h1);
        checkOutput("t2_flag", flag_a, 32'h1);
        checkOutput("t2_ffi", ffi_a, 32'h0);

        $display("[TB] restart from done, two mismatches keep first index");
        corrupt_a = 4'b1100;
        startA();
        checkOutput("t5_valid", valid_a, 32'h1);
        checkOutput("t5_idx", idx_a, 32'h0);
        checkOutput("t5_fail_cleared", fail_a, 32'h0);
        checkOutput("t5_flag_cleared", flag_a, 32'h0);
        checkOutput("t5_pass_cleared", pass_a, 32'h0);
        waitDoneA("t5", 40);
        checkOutput("t5_pass", pass_a, 32'h2);
        checkOutput("t5_fail", fail_a, 32'h2);
        checkOutput("t5_ffi", ffi_a, 32'h2);
        checkOutput("t5_flag", flag_a, 32'h1);

        $display("[TB] step mode pause and resume");
        corrupt_a = 4'b0000;
        step_mode_a = 1'b1;
        startA();
        tick();
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        tick();
        bad_hold = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5) step_mode_a = 1'b0;
            if (busy_a !== 1'b1 || idx_a !== 2'd0 || valid_a !== 1'b0 || pass_a !== 3'd1) bad_hold++;
            tick();
        end
        checkOutput("t3_pause_hold", bad_hold, 32'h0);
        step_a = 1'b1;
        tick();
        step_a = 1'b0;
        checkOutput("t3_next_valid", valid_a, 32'h0);
        tick();
        checkOutput("t3_issue_valid", valid_a, 32'h1);
        checkOutput("t3_issue_idx", idx_a, 32'h1);
        waitDoneA("t3", 40);
        checkOutput("t3_pass", pass_a, 32'h4);

        $display("[TB] reset in the middle of a run");
        corrupt_a = 4'b0001;
        startA();
        repeat (9) tick();
        checkOutput("t4_pre_idx", idx_a, 32'h2);
        checkOutput("t4_pre_busy", busy_a, 32'h1);
        checkOutput("t4_pre_flag", flag_a, 32'h1);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        checkIdleA("t4_rst");
        corrupt_a = 4'b0000;
        repeat (2) tick();
        checkOutput("t4_stays_idle", busy_a, 32'h0);
        startA();
        checkOutput("t4_restart_valid", valid_a, 32'h1);
        checkOutput("t4_restart_idx", idx_a, 32'h0);
        checkOutput("t4_restart_fail", fail_a, 32'h0);
        waitDoneA("t4", 40);
        checkOutput("t4_pass", pass_a, 32'h4);
        checkOutput("t4_flag", flag_a, 32'h0);

        $display("[TB] latency 1 with 32 vectors, single-vector run");
        rst_bc = 1'b1;
        tick();
        start_b = 1'b1;
        start_c = 1'b1;
        tick();
        start_b = 1'b0;
        start_c = 1'b0;
        bad_v = 0;
        bad_d = 0;
        for (int c = 1; c <= 98; c++) begin
            exp_v = (c <= 94) && ((c - 1) % 3 == 0);
            if (valid_b !== exp_v) bad_v++;
            if (done_b !== (c >= 97)) bad_d++;
            if (c == 2) checkOutput("t6_pass_c2", pass_b, 32'h0);
            if (c == 3) checkOutput("t6_pass_c3", pass_b, 32'h1);
            if (c == 1) checkOutput("t6c_valid", valid_c, 32'h1);
            if (c == 5) checkOutput("t6c_done_c5", done_c, 32'h0);
            if (c == 6) checkOutput("t6c_done_c6", done_c, 32'h1);
            if (c == 7) begin
                checkOutput("t6c_pass", pass_c, 32'h1);
                checkOutput("t6c_idx", idx_c, 32'h0);
                checkOutput("t6c_fail", fail_c, 32'h0);
            end
            tick();
        end
        checkOutput("t6_valid_pattern", bad_v, 32'h0);
        checkOutput("t6_done_timing", bad_d, 32'h0);
        checkOutput("t6_pass", pass_b, 32'd31);
        checkOutput("t6_fail", fail_b, 32'h0);
        checkOutput("t6_flag", flag_b, 32'h0);
        checkOutput("t6_idx", idx_b, 32'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
